// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg
//   Shared constants for the instruction-memory program loader: FSM state
//   encoding and the instruction-memory word capacity (MAX_WORDS), which the
//   instruction memory and top level also use.
package imem_program_loader_pkg;

  localparam int MEM_BYTES_DEF = 512;
  localparam int MAX_WORDS     = MEM_BYTES_DEF / 4;

  // Plain vector constants keep the encoding usable by older tooling.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_FINISH  = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;

endpackage

// File: rtl/imem_program_loader_byte_word_packer.sv
// imem_program_loader_byte_word_packer
//   8->32 big-endian shift register with a 2-bit byte counter.
//   clk/reset  : clock, synchronous active-high reset
//   clr        : clear counter and word (new load)
//   shift_en   : a byte transfers this cycle
//   byte_in    : incoming byte, MSB of the word first
//   word_next  : word including the byte currently presented
//   word_ready : this transfer completes a word (4th byte)
module imem_program_loader_byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // Exposing the post-shift word lets the parent capture the complete word
  // on the same edge that accepts the final byte.
  assign word_next  = {word_q[23:0], byte_in};
  assign word_ready = shift_en && (cnt_q == 2'd3);

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = word_next;
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Assembles a big-endian byte stream into 32-bit instruction words and
//   writes them to instruction memory at byte addresses 0,4,8,...; holds the
//   CPU pipeline while loading.
//   Inputs : clk, reset (sync, active high), start, num_words, in_valid, in_data
//   Outputs: in_ready, mem_we, mem_addr, mem_wdata, busy, hold_cpu, done, err
//   Optional: IMEM_LOADER_CHECKSUM_EN adds a CHECK state that accepts one
//   trailing byte and compares it with the XOR of all payload bytes.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int MEM_BYTES  = MEM_BYTES_DEF,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  hold_cpu,
  output logic                  done,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] MAX_W = CNT_WIDTH'(MEM_BYTES / 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit         CSUM_EN = 1'b1;
  localparam logic [2:0] ST_LAST = ST_CHECK;   // state after the final word
`else
  localparam bit         CSUM_EN = 1'b0;
  localparam logic [2:0] ST_LAST = ST_FINISH;
`endif

  logic [2:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  logic        pk_clr, pk_shift, pk_ready;
  logic [31:0] pk_word;

  // Only COLLECT feeds the packer; the checksum byte in CHECK bypasses it.
  assign pk_shift = (state_q == ST_COLLECT) && in_valid;

  imem_program_loader_byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .shift_en   (pk_shift),
    .byte_in    (in_data),
    .word_next  (pk_word),
    .word_ready (pk_ready)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    pk_clr     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words > MAX_W) begin
            err_d = 1'b1;
          end else begin
            err_d      = 1'b0;
            num_d      = num_words;
            word_cnt_d = '0;
            pk_clr     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = (num_words == '0) ? ST_LAST : ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (pk_shift) csum_d = csum_q ^ in_data;
`endif
        if (pk_ready) begin
          // word_cnt < MAX_WORDS here, so the shifted address never wraps.
          addr_d  = {word_cnt_q[ADDR_WIDTH-3:0], 2'b00};
          wdata_d = pk_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_cnt_d = word_cnt_q + 1'b1;
        state_d    = (word_cnt_d == num_q) ? ST_LAST : ST_COLLECT;
      end
      ST_FINISH: state_d = ST_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (in_valid) begin
          if (in_data == csum_q) begin
            state_d = ST_FINISH;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Handshake and status are straight decodes of the state register.
  assign in_ready  = (state_q == ST_COLLECT) || (CSUM_EN && state_q == ST_CHECK);
  assign mem_we    = (state_q == ST_WRITE);
  assign busy      = (state_q == ST_COLLECT) || (state_q == ST_WRITE) ||
                     (CSUM_EN && state_q == ST_CHECK);
  assign hold_cpu  = busy;
  assign done      = (state_q == ST_FINISH);
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader
//   Directed bench for imem_program_loader. Inputs change on the falling
//   edge; outputs are sampled on the falling edge.
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  num_words, in_data;
  logic        in_ready, mem_we, busy, hold_cpu, done, err;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [8:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  csum_m;

  always #5 clk = ~clk;

  imem_program_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .hold_cpu(hold_cpu), .done(done), .err(err)
  );

  // Write log and done counter.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (done) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdy"},  in_ready,  0);
    chk({tag, "_we"},   mem_we,    0);
    chk({tag, "_addr"}, mem_addr,  0);
    chk({tag, "_data"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy,      0);
    chk({tag, "_hold"}, hold_cpu,  0);
    chk({tag, "_done"}, done,      0);
    chk({tag, "_err"},  err,       0);
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1; num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a byte and returns on the falling edge after it transferred.
  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rdy_timeout", 32'(t >= 50), 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Streams words MSB first; checks the write strobe the cycle after each 4th byte.
  task automatic load_words(input logic [31:0] ws[$], input int gap);
    csum_m = 8'h00;
    foreach (ws[i]) begin
      for (int k = 3; k >= 0; k--) begin
        logic [7:0] b;
        b = ws[i][k*8 +: 8];
        csum_m ^= b;
        push_byte(b);
        if (k != 0) repeat (gap) @(negedge clk);
      end
      chk("wr_lat_we",   mem_we,    1);
      chk("wr_lat_rdy",  in_ready,  0);
      chk("wr_lat_addr", mem_addr,  32'(i * 4));
      chk("wr_lat_data", mem_wdata, ws[i]);
      chk("wr_lat_hold", hold_cpu,  1);
    end
  endtask

  // Advances from the last WRITE cycle to the FINISH cycle.
  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_byte(csum_m);
`else
    @(negedge clk);
`endif
  endtask

  task automatic chk_done(input string tag, input int done_before);
    chk({tag, "_done"}, done,     1);
    chk({tag, "_hold"}, hold_cpu, 0);
    chk({tag, "_busy"}, busy,     0);
    chk({tag, "_err"},  err,      0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_ndone"}, 32'(n_done - done_before), 1);
  endtask

  initial begin
    logic [31:0] ws[$];
    int nd;
    reset = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("idle");

    // Byte offered while not ready must not be consumed or written.
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("idle_rdy", in_ready, 0);
    chk("idle_nwr", wr_addr.size(), 0);
    in_valid = 1'b0;

    // Two words, back-to-back bytes.
    nd = n_done;
    do_start(8'd2);
    chk("t2_busy", busy, 1);
    chk("t2_hold", hold_cpu, 1);
    ws = '{32'h20010005, 32'h8C220004};
    load_words(ws, 0);
    finish_load();
    chk_done("t2", nd);
    chk("t2_nwr", wr_addr.size(), 2);
    chk("t2_a0", wr_addr[0], 0);
    chk("t2_d0", wr_data[0], 32'h20010005);
    chk("t2_a1", wr_addr[1], 4);
    chk("t2_d1", wr_data[1], 32'h8C220004);
    chk("t2_addr_hold", mem_addr,  4);
    chk("t2_data_hold", mem_wdata, 32'h8C220004);

    // One word with 3-cycle gaps between bytes.
    wr_addr.delete(); wr_data.delete();
    nd = n_done;
    do_start(8'd1);
    ws = '{32'hDEADBEEF};
    load_words(ws, 3);
    finish_load();
    chk_done("t3", nd);
    chk("t3_nwr", wr_addr.size(), 1);
    chk("t3_a0", wr_addr[0], 0);
    chk("t3_d0", wr_data[0], 32'hDEADBEEF);

    // Oversized request, then empty request.
    wr_addr.delete(); wr_data.delete();
    do_start(8'd129);
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_rdy", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", err, 1);
    chk("t4_nwr", wr_addr.size(), 0);
    nd = n_done;
    do_start(8'd0);
    chk("t4z_err_clr", err, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_byte(8'h00);
`endif
    chk_done("t4z", nd);
    chk("t4z_nwr", wr_addr.size(), 0);

    // Reset in the middle of a three-word load.
    wr_addr.delete(); wr_data.delete();
    do_start(8'd3);
    ws = '{32'hCAFEF00D};
    load_words(ws, 0);
    push_byte(8'h11);
    chk("t5_hold_pre", hold_cpu, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("t5_rst");
    reset = 1'b0;
    chk("t5_nwr", wr_addr.size(), 1);
    chk("t5_a0", wr_addr[0], 0);
    wr_addr.delete(); wr_data.delete();
    nd = n_done;
    do_start(8'd1);
    ws = '{32'h12345678};
    load_words(ws, 0);
    finish_load();
    chk_done("t5r", nd);
    chk("t5r_nwr", wr_addr.size(), 1);
    chk("t5r_a0", wr_addr[0], 0);
    chk("t5r_d0", wr_data[0], 32'h12345678);

    // Full memory: last write lands at MEM_BYTES-4.
    wr_addr.delete(); wr_data.delete();
    ws.delete();
    for (int i = 0; i < MAX_WORDS; i++) ws.push_back({4{8'(i)}});
    nd = n_done;
    do_start(8'(MAX_WORDS));
    chk("t6_err", err, 0);
    load_words(ws, 0);
    finish_load();
    chk_done("t6", nd);
    chk("t6_nwr", wr_addr.size(), 128);
    chk("t6_alast", wr_addr[127], 508);
    chk("t6_dlast", wr_data[127], 32'h7F7F7F7F);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match, then mismatch.
    nd = n_done;
    do_start(8'd1);
    ws = '{32'h01020304};
    load_words(ws, 0);
    chk("t7_csum_model", csum_m, 8'h04);
    push_byte(8'h04);
    chk_done("t7", nd);
    nd = n_done;
    do_start(8'd1);
    load_words(ws, 0);
    push_byte(8'h05);
    chk("t7b_err",  err,      1);
    chk("t7b_done", done,     0);
    chk("t7b_hold", hold_cpu, 0);
    chk("t7b_busy", busy,     0);
    @(negedge clk);
    chk("t7b_ndone", 32'(n_done - nd), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
